// File: rtl/pcb_unlock_pkg.sv
// Shared definitions for the unlock sequencer: secret table, length and FSM encoding.
package pcb_unlock_pkg;

  localparam int unsigned SEQ_LEN = 19;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_e;

  // Expected character at each sequence position; out-of-range never matches a real key path.
  function automatic logic [7:0] seq_char(input logic [4:0] idx);
    logic [7:0] c;
    case (idx)
      5'd0:    c = 8'd83;
      5'd1:    c = 8'd52;
      5'd2:    c = 8'd116;
      5'd3:    c = 8'd95;
      5'd4:    c = 8'd115;
      5'd5:    c = 8'd48;
      5'd6:    c = 8'd49;
      5'd7:    c = 8'd118;
      5'd8:    c = 8'd101;
      5'd9:    c = 8'd82;
      5'd10:   c = 8'd95;
      5'd11:   c = 8'd105;
      5'd12:   c = 8'd53;
      5'd13:   c = 8'd95;
      5'd14:   c = 8'd71;
      5'd15:   c = 8'd114;
      5'd16:   c = 8'd57;
      5'd17:   c = 8'd97;
      5'd18:   c = 8'd55;
      default: c = 8'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pcb_unlock_timer.sv
// Loadable down-counter shared by lockout and entry timeout; stops at zero.
module pcb_unlock_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_r;

  // Load takes priority over counting; counter saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {WIDTH{1'b0}})) begin
      cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/pcb_unlock_seq.sv
// Unlock sequencer: matches keys against the secret table, locks out after repeated failures.
// Optional entry timeout is compiled in when PCB_UNLOCK_TIMEOUT_EN is defined.
module pcb_unlock_seq
  import pcb_unlock_pkg::*;
#(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       relock,
  output logic       unlocked,
  output logic       locked_out,
  output logic [4:0] progress,
  output logic [3:0] fail_cnt,
  output logic       error
);

`ifdef PCB_UNLOCK_TIMEOUT_EN
  localparam logic TIMEOUT_EN_C = 1'b1;
`else
  localparam logic TIMEOUT_EN_C = 1'b0;
`endif

  // Counters are loaded with N-1 so the zero flag ends the wait after exactly N cycles.
  localparam logic [3:0]  MAX_FAILS_C    = 4'(MAX_FAILS);
  localparam logic [15:0] LOCK_LOAD_C    = 16'(LOCKOUT_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LOAD_C = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  SEQ_LAST_C     = 5'(SEQ_LEN - 1);

  state_e      state_r, state_s;
  logic [4:0]  progress_r, progress_s;
  logic [3:0]  fail_cnt_r, fail_cnt_s;
  logic        error_r, error_s;
  logic        unlocked_r, unlocked_s;
  logic        locked_out_r, locked_out_s;
  logic        key_ready_r, key_ready_s;

  logic        take_s, match_s, miss_s, last_s, timeout_s, fail_s, lock_s;
  logic [3:0]  fail_inc_s;
  logic        tmr_load_s, tmr_en_s, tmr_zero_s;
  logic [15:0] tmr_load_val_s;

  // Relock in ENTRY drops a simultaneous key entirely.
  assign take_s     = key_valid && key_ready_r && !(relock && (state_r == ST_ENTRY));
  assign match_s    = take_s && (key == seq_char(progress_r));
  assign miss_s     = take_s && !match_s;
  assign last_s     = match_s && (progress_r == SEQ_LAST_C);
  assign timeout_s  = TIMEOUT_EN_C && (state_r == ST_ENTRY) && !relock && !take_s && tmr_zero_s;
  assign fail_s     = miss_s || timeout_s;
  assign fail_inc_s = fail_cnt_r + 4'd1;
  assign lock_s     = fail_s && (fail_inc_s == MAX_FAILS_C);

  pcb_unlock_timer #(.WIDTH(16)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_load_val_s),
    .en       (tmr_en_s),
    .zero     (tmr_zero_s)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      progress_r   <= 5'd0;
      fail_cnt_r   <= 4'd0;
      error_r      <= 1'b0;
      unlocked_r   <= 1'b0;
      locked_out_r <= 1'b0;
      key_ready_r  <= 1'b1;
    end else begin
      state_r      <= state_s;
      progress_r   <= progress_s;
      fail_cnt_r   <= fail_cnt_s;
      error_r      <= error_s;
      unlocked_r   <= unlocked_s;
      locked_out_r <= locked_out_s;
      key_ready_r  <= key_ready_s;
    end
  end

  // Next-state logic and timer control.
  always_comb begin
    state_s        = state_r;
    tmr_load_s     = 1'b0;
    tmr_load_val_s = TIMEOUT_LOAD_C;
    tmr_en_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_ENTRY: begin
        if ((state_r == ST_ENTRY) && relock) begin
          state_s = ST_IDLE;
        end else if (lock_s) begin
          state_s        = ST_LOCKOUT;
          tmr_load_s     = 1'b1;
          tmr_load_val_s = LOCK_LOAD_C;
        end else if (fail_s) begin
          state_s = ST_IDLE;
        end else if (last_s) begin
          state_s = ST_UNLOCKED;
        end else if (match_s) begin
          state_s    = ST_ENTRY;
          tmr_load_s = TIMEOUT_EN_C;
        end else begin
          state_s  = state_r;
          tmr_en_s = TIMEOUT_EN_C && (state_r == ST_ENTRY);
        end
      end
      ST_UNLOCKED: begin
        if (relock) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_UNLOCKED;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_zero_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s  = ST_LOCKOUT;
          tmr_en_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    progress_s = progress_r;
    fail_cnt_s = fail_cnt_r;
    error_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_ENTRY: begin
        if ((state_r == ST_ENTRY) && relock) begin
          progress_s = 5'd0;
        end else if (fail_s) begin
          progress_s = 5'd0;
          error_s    = 1'b1;
          fail_cnt_s = lock_s ? MAX_FAILS_C : fail_inc_s;
        end else if (match_s) begin
          progress_s = progress_r + 5'd1;
          fail_cnt_s = last_s ? 4'd0 : fail_cnt_r;
        end else begin
          progress_s = progress_r;
        end
      end
      ST_UNLOCKED: begin
        if (relock) begin
          progress_s = 5'd0;
          fail_cnt_s = 4'd0;
        end else begin
          progress_s = progress_r;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_zero_s) begin
          fail_cnt_s = 4'd0;
        end else begin
          fail_cnt_s = fail_cnt_r;
        end
      end
      default: begin
        progress_s = 5'd0;
        fail_cnt_s = 4'd0;
      end
    endcase
    unlocked_s   = (state_s == ST_UNLOCKED);
    locked_out_s = (state_s == ST_LOCKOUT);
    key_ready_s  = (state_s == ST_IDLE) || (state_s == ST_ENTRY);
  end

  assign key_ready  = key_ready_r;
  assign unlocked   = unlocked_r;
  assign locked_out = locked_out_r;
  assign progress   = progress_r;
  assign fail_cnt   = fail_cnt_r;
  assign error      = error_r;

endmodule

// File: tb/tb_pcb_unlock_seq.sv
// Scoreboard bench for pcb_unlock_seq: directed vectors push expected outputs, a monitor compares.
module tb_pcb_unlock_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key = 8'd0;
  logic       key_valid = 1'b0;
  logic       relock = 1'b0;
  logic       key_ready, unlocked, locked_out, error;
  logic [4:0] progress;
  logic [3:0] fail_cnt;

  typedef struct packed {
    logic [4:0] prog;
    logic [3:0] fails;
    logic       unl;
    logic       lo;
    logic       err;
    logic       rdy;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  obs_t  mon_e;
  string mon_nm;
  int    checks = 0;
  int    errors = 0;

  logic [7:0] seq_tb [0:18] = '{8'd83, 8'd52, 8'd116, 8'd95, 8'd115, 8'd48, 8'd49,
                                8'd118, 8'd101, 8'd82, 8'd95, 8'd105, 8'd53, 8'd95,
                                8'd71, 8'd114, 8'd57, 8'd97, 8'd55};

  always #5 clk = ~clk;

  pcb_unlock_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .relock     (relock),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .progress   (progress),
    .fail_cnt   (fail_cnt),
    .error      (error)
  );

  function automatic obs_t ob(input logic [4:0] p, input logic [3:0] f, input logic u,
                              input logic l, input logic e, input logic r);
    obs_t o;
    o.prog = p; o.fails = f; o.unl = u; o.lo = l; o.err = e; o.rdy = r;
    return o;
  endfunction

  task automatic compare(input obs_t e, input string nm);
    obs_t a;
    a.prog = progress; a.fails = fail_cnt; a.unl = unlocked;
    a.lo = locked_out; a.err = error; a.rdy = key_ready;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got prog=%0d fails=%0d unl=%b lo=%b err=%b rdy=%b, expected prog=%0d fails=%0d unl=%b lo=%b err=%b rdy=%b",
               nm, a.prog, a.fails, a.unl, a.lo, a.err, a.rdy,
               e.prog, e.fails, e.unl, e.lo, e.err, e.rdy);
    end
  endtask

  // Monitor: after each rising edge, compare against the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      compare(mon_e, mon_nm);
    end
  end

  task automatic step(input logic [7:0] k, input logic v, input logic rl,
                      input obs_t e, input string nm);
    @(negedge clk);
    key = k; key_valid = v; relock = rl;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must reach reset values before any clock edge.
  task automatic async_reset(input string nm);
    @(negedge clk);
    key_valid = 1'b0; relock = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    compare(ob(5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), nm);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare(ob(5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "reset_state");
    rst_n = 1'b1;

    // Three correct keys, then a wrong one.
    step(8'd83,  1'b1, 1'b0, ob(5'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "k83");
    step(8'd52,  1'b1, 1'b0, ob(5'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "k52");
    step(8'd116, 1'b1, 1'b0, ob(5'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "k116");
    step(8'd0,   1'b1, 1'b0, ob(5'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1), "wrong_at3");
    step(8'd0,   1'b0, 1'b0, ob(5'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1), "err_one_cycle");
    step(8'd0,   1'b1, 1'b0, ob(5'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1), "wrong_idle");

    // Full sequence back-to-back; unlock clears the failure count.
    for (int i = 0; i < 19; i++) begin
      step(seq_tb[i], 1'b1, 1'b0,
           ob(5'(i + 1), (i == 18) ? 4'd0 : 4'd2, (i == 18), 1'b0, 1'b0, (i != 18)),
           "unlock_seq");
    end
    step(8'd83, 1'b1, 1'b0, ob(5'd19, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), "unlocked_hold");
    step(8'd0,  1'b0, 1'b1, ob(5'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "relock_unlocked");

    // Three wrong keys -> 16 cycles of lockout; relock is ignored there.
    step(8'd1, 1'b1, 1'b0, ob(5'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1), "lk_wrong1");
    step(8'd2, 1'b1, 1'b0, ob(5'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1), "lk_wrong2");
    step(8'd3, 1'b1, 1'b0, ob(5'd0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0), "lk_enter");
    for (int i = 0; i < 15; i++) begin
      step(8'd83, 1'b1, (i == 5), ob(5'd0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0), "lk_hold");
    end
    step(8'd0,  1'b0, 1'b0, ob(5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "lk_exit");
    step(8'd83, 1'b1, 1'b0, ob(5'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "post_lk_key");

    // Relock with a simultaneous key at progress 7.
    for (int i = 1; i < 7; i++) begin
      step(seq_tb[i], 1'b1, 1'b0, ob(5'(i + 1), 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "to_p7");
    end
    step(seq_tb[7], 1'b1, 1'b1, ob(5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "relock_prio");
    step(seq_tb[7], 1'b1, 1'b0, ob(5'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1), "key_after_relock");

    // A wrong key equal to SEQ[0] is discarded, not restarted on.
    step(8'd83, 1'b1, 1'b0, ob(5'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1), "restart83");
    step(8'd83, 1'b1, 1'b0, ob(5'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1), "discard_not_seq0");

    // Reset in the middle of an entry.
    for (int i = 0; i < 10; i++) begin
      step(seq_tb[i], 1'b1, 1'b0, ob(5'(i + 1), 4'd2, 1'b0, 1'b0, 1'b0, 1'b1), "to_p10");
    end
    async_reset("rst_mid_entry");
    step(8'd0, 1'b0, 1'b0, ob(5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "after_rst_entry");

    // Idle gap in ENTRY.
    for (int i = 0; i < 4; i++) begin
      step(seq_tb[i], 1'b1, 1'b0, ob(5'(i + 1), 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "to_p4");
    end
`ifdef PCB_UNLOCK_TIMEOUT_EN
    repeat (63) step(8'd0, 1'b0, 1'b0, ob(5'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "to_wait");
    step(8'd0, 1'b0, 1'b0, ob(5'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1), "to_fire");
    step(8'd0, 1'b0, 1'b0, ob(5'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1), "to_clear");
`else
    repeat (100) step(8'd0, 1'b0, 1'b0, ob(5'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "no_timeout");
`endif
    async_reset("rst_clean");

    // Reset during lockout.
    step(8'd9, 1'b1, 1'b0, ob(5'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1), "lk2_wrong1");
    step(8'd9, 1'b1, 1'b0, ob(5'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1), "lk2_wrong2");
    step(8'd9, 1'b1, 1'b0, ob(5'd0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0), "lk2_enter");
    repeat (4) step(8'd0, 1'b0, 1'b0, ob(5'd0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0), "lk2_hold");
    async_reset("rst_mid_lockout");
    step(8'd0,  1'b0, 1'b0, ob(5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "after_rst_lk");
    step(8'd83, 1'b1, 1'b0, ob(5'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), "key_after_rst_lk");

    @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
